can_rx_frame_fifo: RTL and testbench
====================================

// Module: can_rx_frame_fifo
// PURPOSE
//  Receive FIFO downstream of the acceptance filter. It stores accepted frames
//  byte by byte in a 64-byte ring buffer, together with a per-frame length
//  queue. A frame becomes visible to the host only when the filter commits it;
//  a rejected or aborted frame leaves no trace in the buffer. The host reads
//  through a 13-byte window, releases frames one at a time, and sees a frame
//  count (RMC) and a data-overrun flag.
// PARAMETERS
//  DEPTH_LOG2  6   log2 of data RAM size in bytes (64)
//  MAX_FRAMES  64  depth of the length queue; a power of two, <= 2**DEPTH_LOG2
//  MAX_LEN     13  maximum bytes per frame (4 bytes EFF header + 1 info byte + 8 data)
// PORTS
//  clk             in   1   system clock
//  rst             in   1   reset, asynchronous, active-high
//  reset_mode      in   1   controller in reset mode: synchronous clear of FIFO state
//  frame_start     in   1   start of a new frame: clears the tentative length
//  wr_en           in   1   write one byte of the frame being received
//  wr_data         in   8   byte to write
//  frame_commit    in   1   filter accepted and frame complete: publish it
//  frame_abort     in   1   filter rejected the frame, or bus error: discard it
//  rd_offset       in   4   byte offset (0..12) from the head of the oldest frame
//  rd_data         out  8   mem[(rd_ptr+rd_offset) mod 2**DEPTH_LOG2], combinational
//  release_buffer  in   1   pop the oldest frame (RRB command), one-cycle pulse
//  overrun_clear   in   1   clear data_overrun (CDO command)
//  frame_count     out  7   committed frames held, 0..MAX_FRAMES
//  frame_pending   out  1   frame_count != 0 (drives the RI interrupt)
//  data_overrun    out  1   sticky: a frame was lost for lack of space
//  bytes_used      out  7   committed bytes held, 0..64
// BEHAVIOUR
//  Reset (rst or reset_mode): wr_ptr, rd_ptr, tmp_ptr, len_tmp, queue pointers,
//   frame_count, bytes_used and data_overrun all go to 0; frame_bad is cleared.
//   rd_data shows mem[0]; RAM contents are not cleared.
//  Write: frame_start loads tmp_ptr <= wr_ptr, len_tmp <= 0 and frame_bad <= 0.
//   Each wr_en with !frame_bad writes mem[tmp_ptr] and increments tmp_ptr and
//   len_tmp (mod 2**DEPTH_LOG2).
//  Space check on each wr_en: if bytes_used + len_tmp == 64, or len_tmp == MAX_LEN,
//   set frame_bad and drop the byte. The RAM is never written past rd_ptr.
//  Commit (next edge): if !frame_bad and frame_count < MAX_FRAMES, push len_tmp to
//   the length queue, set wr_ptr <= tmp_ptr, frame_count +1, bytes_used += len_tmp.
//   Otherwise drop the frame. If the drop is caused by lack of space or a full
//   queue, set data_overrun <= 1. A zero-length commit is ignored.
//  Abort: discard the frame; wr_ptr is unchanged and data_overrun is not set.
//  wr_en with frame_commit in the same cycle: the byte is written first and
//   counted in the committed length. frame_commit and frame_abort together:
//   abort wins.
//  Release: if frame_count != 0, rd_ptr += head length, pop the queue,
//   frame_count -1, bytes_used -= length. Release on an empty FIFO is ignored.
//  Commit and release in the same cycle: both apply. frame_count stays the same;
//   bytes_used = bytes_used + len_tmp - head_len. The space check uses the
//   pre-release bytes_used, which is conservative.
//  overrun_clear clears data_overrun. If a new overrun happens in the same cycle,
//   the set wins.
//  Latency: the frame is visible (frame_count, rd_data) one cycle after the
//   frame_commit edge. rd_data follows rd_offset and rd_ptr combinationally.
//  Wrap-around: all pointer and address arithmetic is mod 2**DEPTH_LOG2. A frame
//   may straddle the end of the RAM.
// TESTING
//  1. SFF frame, DLC=0: frame_start, 3 bytes 0x00,0x24,0x60, commit ->
//     frame_count=1, frame_pending=1, rd_data at offsets 0..2 = 0x00,0x24,0x60;
//     release -> frame_count=0, bytes_used=0.
//  2. Abort after 5 bytes, then commit a 3-byte frame -> frame_count=1,
//     offset 0 = first byte of the committed frame, data_overrun=0.
//  3. Four 13-byte frames, then a 13-byte frame (space 12) -> frame 5 dropped,
//     data_overrun=1, frame_count=4, bytes_used=52; overrun_clear -> 0.
//  4. Wrap: commit and release 60 bytes in total, then commit a 10-byte frame ->
//     bytes 4..9 read correctly across the wrap at address 63->0.
//  5. Commit and release in the same cycle with frame_count=1 -> frame_count=1,
//     rd_ptr advanced by the old head length; release with frame_count=0 is a no-op.
//  6. reset_mode pulse with 2 frames held -> frame_count=0, data_overrun=0,
//     bytes_used=0; rst asserted mid-frame, then commit -> nothing stored.

Source files
------------

// File: rtl/can_rx_frame_fifo_if.sv
// Host/filter side bundle of the CAN receive frame FIFO.
// master drives frames and host commands; slave is the FIFO.
interface can_rx_frame_fifo_if;
    logic       reset_mode;
    logic       frame_start;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       frame_commit;
    logic       frame_abort;
    logic [3:0] rd_offset;
    logic [7:0] rd_data;
    logic       release_buffer;
    logic       overrun_clear;
    logic [6:0] frame_count;
    logic       frame_pending;
    logic       data_overrun;
    logic [6:0] bytes_used;

    modport master (
        output reset_mode, frame_start, wr_en, wr_data,
        output frame_commit, frame_abort, rd_offset,
        output release_buffer, overrun_clear,
        input  rd_data, frame_count, frame_pending,
        input  data_overrun, bytes_used
    );

    modport slave (
        input  reset_mode, frame_start, wr_en, wr_data,
        input  frame_commit, frame_abort, rd_offset,
        input  release_buffer, overrun_clear,
        output rd_data, frame_count, frame_pending,
        output data_overrun, bytes_used
    );
endinterface

// File: rtl/can_rx_frame_fifo.sv
// CAN receive FIFO: byte ring buffer plus per-frame length queue.
// Frames become visible only on commit; aborted frames leave no trace.
module can_rx_frame_fifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int MAX_FRAMES = 64,
    parameter int MAX_LEN    = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    can_rx_frame_fifo_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int QW    = $clog2(MAX_FRAMES);
    localparam int LW    = $clog2(MAX_LEN + 1);
    localparam int AW    = DEPTH_LOG2;

    logic [7:0]    mem  [DEPTH];
    logic [LW-1:0] lenq [MAX_FRAMES];

    logic [AW-1:0] wr_ptr, rd_ptr, tmp_ptr;
    logic [QW-1:0] q_wr, q_rd;
    logic [6:0]    len_tmp, cnt_q, used_q;
    logic          frame_bad, bad_space, ovr_q;

    logic [AW-1:0] st_ptr, ptr_now;
    logic [6:0]    st_len, len_now;
    logic          st_bad, st_space;
    logic [7:0]    fill;
    logic          full_hit, long_hit, do_wr;
    logic          bad_now, space_now;
    logic          commit, push, pop, ovr_set;
    logic [LW-1:0] head_len;

    // frame_start in the same cycle as a byte opens the frame first
    always_comb begin
        st_ptr   = bus.frame_start ? wr_ptr : tmp_ptr;
        st_len   = bus.frame_start ? 7'd0   : len_tmp;
        st_bad   = bus.frame_start ? 1'b0   : frame_bad;
        st_space = bus.frame_start ? 1'b0   : bad_space;
    end

    always_comb begin
        fill      = {1'b0, used_q} + {1'b0, st_len};
        full_hit  = (fill == 8'(DEPTH));
        long_hit  = (st_len == 7'(MAX_LEN));
        do_wr     = bus.wr_en && !st_bad && !full_hit && !long_hit;
        bad_now   = st_bad || (bus.wr_en && (full_hit || long_hit));
        space_now = st_space || (bus.wr_en && !st_bad && full_hit);
        len_now   = st_len + 7'(do_wr);
        ptr_now   = st_ptr + AW'(do_wr);
    end

    // Space check uses pre-release occupancy and count
    always_comb begin
        head_len = lenq[q_rd];
        commit   = bus.frame_commit && !bus.frame_abort;
        push     = commit && !bad_now && (len_now != 7'd0)
                   && (cnt_q < 7'(MAX_FRAMES));
        ovr_set  = commit && (space_now
                   || (!bad_now && (len_now != 7'd0)
                       && (cnt_q >= 7'(MAX_FRAMES))));
        pop      = bus.release_buffer && (cnt_q != 7'd0);
    end

    always_ff @(posedge clk) begin
        if (do_wr && !bus.reset_mode)
            mem[st_ptr] <= bus.wr_data;
        if (push && !bus.reset_mode)
            lenq[q_wr] <= LW'(len_now);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tmp_ptr   <= '0;
            q_wr      <= '0;
            q_rd      <= '0;
            len_tmp   <= '0;
            cnt_q     <= '0;
            used_q    <= '0;
            frame_bad <= 1'b0;
            bad_space <= 1'b0;
            ovr_q     <= 1'b0;
        end else if (bus.reset_mode) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tmp_ptr   <= '0;
            q_wr      <= '0;
            q_rd      <= '0;
            len_tmp   <= '0;
            cnt_q     <= '0;
            used_q    <= '0;
            frame_bad <= 1'b0;
            bad_space <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            if (bus.frame_commit || bus.frame_abort) begin
                tmp_ptr   <= push ? ptr_now : wr_ptr;
                len_tmp   <= '0;
                frame_bad <= 1'b0;
                bad_space <= 1'b0;
            end else begin
                tmp_ptr   <= ptr_now;
                len_tmp   <= len_now;
                frame_bad <= bad_now;
                bad_space <= space_now;
            end
            if (push) begin
                wr_ptr <= ptr_now;
                q_wr   <= q_wr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(head_len);
                q_rd   <= q_rd + 1'b1;
            end
            cnt_q  <= cnt_q + 7'(push) - 7'(pop);
            used_q <= used_q + (push ? len_now : 7'd0)
                      - (pop ? 7'(head_len) : 7'd0);
            if (ovr_set)
                ovr_q <= 1'b1;
            else if (bus.overrun_clear)
                ovr_q <= 1'b0;
        end
    end

    assign bus.rd_data       = mem[rd_ptr + AW'(bus.rd_offset)];
    assign bus.frame_count   = cnt_q;
    assign bus.frame_pending = (cnt_q != 7'd0);
    assign bus.data_overrun  = ovr_q;
    assign bus.bytes_used    = used_q;
endmodule

// File: tb/tb_can_rx_frame_fifo.sv
// Bench for can_rx_frame_fifo: directed cases plus random traffic
// compared against a queue-based model of committed frames.
module tb_can_rx_frame_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    can_rx_frame_fifo_if bus ();
    can_rx_frame_fifo dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Model: committed bytes in arrival order, one length per frame
    logic [7:0] mq[$];
    int         lq[$];
    logic [7:0] pq[$];
    bit         pbad, psp, movr;

    task automatic model_reset();
        mq.delete(); lq.delete(); pq.delete();
        pbad = 0; psp = 0; movr = 0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input int off, input int exp);
        bus.rd_offset = 4'(off);
        #1;
        chk($sformatf("rd_data[%0d]", off), int'(bus.rd_data), exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, int'(bus.frame_count), lq.size());
        chk({tag, ".pending"}, int'(bus.frame_pending),
            int'(lq.size() != 0));
        chk({tag, ".overrun"}, int'(bus.data_overrun), int'(movr));
        chk({tag, ".used"}, int'(bus.bytes_used), mq.size());
        if (lq.size() != 0)
            for (int i = 0; i < lq[0]; i++)
                chk_rd(i, int'(mq[i]));
    endtask

    task automatic step(input bit st, input bit we, input logic [7:0] b,
                        input bit cm, input bit ab, input bit rl,
                        input bit oc, input bit rm);
        int had;
        bit ovr_new;
        ovr_new = 0;
        had = lq.size();
        if (rm) model_reset();
        else begin
            if (st) begin pq.delete(); pbad = 0; psp = 0; end
            if (we && !pbad) begin
                if (mq.size() + pq.size() == 64) begin
                    pbad = 1; psp = 1;
                end else if (pq.size() == 13) pbad = 1;
                else pq.push_back(b);
            end
            if (ab) begin
                pq.delete(); pbad = 0; psp = 0;
            end else if (cm) begin
                if (pbad) ovr_new = psp;
                else if (pq.size() != 0) begin
                    if (had == 64) ovr_new = 1;
                    else begin
                        foreach (pq[i]) mq.push_back(pq[i]);
                        lq.push_back(pq.size());
                    end
                end
                pq.delete(); pbad = 0; psp = 0;
            end
            if (rl && had != 0) begin
                int n;
                n = lq.pop_front();
                repeat (n) void'(mq.pop_front());
            end
            if (ovr_new) movr = 1;
            else if (oc) movr = 0;
        end
        bus.frame_start = st; bus.wr_en = we; bus.wr_data = b;
        bus.frame_commit = cm; bus.frame_abort = ab;
        bus.release_buffer = rl; bus.overrun_clear = oc;
        bus.reset_mode = rm;
        @(posedge clk);
        #1;
        bus.frame_start = 0; bus.wr_en = 0; bus.wr_data = 0;
        bus.frame_commit = 0; bus.frame_abort = 0;
        bus.release_buffer = 0; bus.overrun_clear = 0;
        bus.reset_mode = 0;
    endtask

    task automatic t_start();  step(1,0,0,0,0,0,0,0); endtask
    task automatic t_wr(input logic [7:0] b); step(0,1,b,0,0,0,0,0); endtask
    task automatic t_commit(); step(0,0,0,1,0,0,0,0); endtask
    task automatic t_abort();  step(0,0,0,0,1,0,0,0); endtask
    task automatic t_rel();    step(0,0,0,0,0,1,0,0); endtask
    task automatic t_oclr();   step(0,0,0,0,0,0,1,0); endtask
    task automatic t_rm();     step(0,0,0,0,0,0,0,1); endtask

    task automatic frame(input int n, input logic [7:0] base);
        t_start();
        for (int i = 0; i < n; i++) t_wr(base + 8'(i));
        t_commit();
    endtask

    initial begin
        bus.frame_start = 0; bus.wr_en = 0; bus.wr_data = 0;
        bus.frame_commit = 0; bus.frame_abort = 0;
        bus.release_buffer = 0; bus.overrun_clear = 0;
        bus.reset_mode = 0; bus.rd_offset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check_all("reset");

        // SFF frame with DLC=0
        t_start(); t_wr(8'h00); t_wr(8'h24); t_wr(8'h60); t_commit();
        chk("t1.count", int'(bus.frame_count), 1);
        chk("t1.pending", int'(bus.frame_pending), 1);
        chk_rd(0, 'h00); chk_rd(1, 'h24); chk_rd(2, 'h60);
        t_rel();
        chk("t1.count_rel", int'(bus.frame_count), 0);
        chk("t1.used_rel", int'(bus.bytes_used), 0);
        check_all("t1");

        // Aborted frame leaves no trace
        t_start();
        for (int i = 0; i < 5; i++) t_wr(8'h90 + 8'(i));
        t_abort();
        frame(3, 8'h31);
        chk("t2.count", int'(bus.frame_count), 1);
        chk_rd(0, 'h31);
        chk("t2.overrun", int'(bus.data_overrun), 0);
        check_all("t2");

        // Fifth 13-byte frame overruns
        t_rm();
        for (int f = 0; f < 4; f++) frame(13, 8'(f * 16));
        frame(13, 8'hE0);
        chk("t3.overrun", int'(bus.data_overrun), 1);
        chk("t3.count", int'(bus.frame_count), 4);
        chk("t3.used", int'(bus.bytes_used), 52);
        check_all("t3");
        t_oclr();
        chk("t3.oclr", int'(bus.data_overrun), 0);

        // Wrap across address 63 -> 0
        t_rm();
        for (int f = 0; f < 5; f++) begin
            frame(12, 8'(f * 12)); t_rel();
        end
        frame(10, 8'hA0);
        for (int i = 4; i < 10; i++) chk_rd(i, 'hA0 + i);
        check_all("t4");

        // Commit and release together
        t_rm();
        frame(2, 8'h11);
        t_start(); t_wr(8'h33); t_wr(8'h44); t_wr(8'h55);
        step(0,0,0,1,0,1,0,0);
        chk("t5.count", int'(bus.frame_count), 1);
        chk("t5.used", int'(bus.bytes_used), 3);
        chk_rd(0, 'h33);
        t_rel(); t_rel();
        chk("t5.empty_rel", int'(bus.frame_count), 0);
        chk("t5.used0", int'(bus.bytes_used), 0);

        // reset_mode and async reset mid-frame
        frame(4, 8'h01); frame(5, 8'h21);
        t_rm();
        chk("t6.count", int'(bus.frame_count), 0);
        chk("t6.overrun", int'(bus.data_overrun), 0);
        chk("t6.used", int'(bus.bytes_used), 0);
        t_start(); t_wr(8'h77); t_wr(8'h78);
        rst = 1; #3 rst = 0;
        model_reset();
        t_commit();
        chk("t6.rst_count", int'(bus.frame_count), 0);
        chk("t6.rst_used", int'(bus.bytes_used), 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 60,
                 8'($urandom),
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 9,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 999) < 4);
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
